// File: rtl/mu0_mem_if.sv
// MU0 memory request/acknowledge bundle.
// The sequencer drives request and direction; memory answers with mem_ack.
interface mu0_mem_if;
    logic MEMrq;
    logic RnW;
    logic mem_ack;

    modport master (
        output MEMrq,
        output RnW,
        input  mem_ack
    );

    modport slave (
        input  MEMrq,
        input  RnW,
        output mem_ack
    );
endinterface

// File: rtl/mu0_control.sv
// MU0 fetch/execute sequencer with memory handshake,
// single-step pause and retired-instruction counter.
module mu0_control #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [3:0]       F,
    input  logic             N,
    input  logic             Z,
    input  logic             step_en,
    input  logic             step,
    mu0_mem_if.master        mem,
    output logic             Asel,
    output logic             Xsel,
    output logic             Ysel,
    output logic [1:0]       M,
    output logic             PCEn,
    output logic             IREn,
    output logic             AccEn,
    output logic             Halted,
    output logic             fetch,
    output logic [CNT_W-1:0] instr_count
);

    typedef enum logic [1:0] {
        S_FETCH,
        S_EXEC,
        S_PAUSE,
        S_HALT
    } state_t;

    localparam logic [CNT_W-1:0] ONE = 1;

    state_t            r_state;
    state_t            w_next;
    logic [CNT_W-1:0]  r_count;
    logic              w_retire;
    logic              w_memrq;
    logic              w_rnw;
    logic              w_ack;

    assign mem.MEMrq   = w_memrq;
    assign mem.RnW     = w_rnw;
    assign w_ack       = mem.mem_ack;
    assign instr_count = r_count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_FETCH;
            r_count <= '0;
        end else begin
            r_state <= w_next;
            if (w_retire)
                r_count <= r_count + ONE;
        end
    end

    always_comb begin
        w_next   = r_state;
        w_retire = 1'b0;
        w_memrq  = 1'b0;
        w_rnw    = 1'b1;
        Asel     = 1'b0;
        Xsel     = 1'b0;
        Ysel     = 1'b0;
        M        = 2'b00;
        PCEn     = 1'b0;
        IREn     = 1'b0;
        AccEn    = 1'b0;
        Halted   = 1'b0;
        fetch    = 1'b0;

        unique case (r_state)
            S_FETCH: begin
                fetch   = 1'b1;
                w_memrq = 1'b1;
                Xsel    = 1'b1;
                M       = 2'b10;
                IREn    = w_ack;
                PCEn    = w_ack;
                if (w_ack)
                    w_next = S_EXEC;
            end
            S_EXEC: begin
                // Memory ops wait for mem_ack; everything else retires now.
                w_retire = 1'b1;
                case (F)
                    4'd0: begin
                        Asel     = 1'b1;
                        w_memrq  = 1'b1;
                        AccEn    = w_ack;
                        w_retire = w_ack;
                    end
                    4'd1: begin
                        Asel     = 1'b1;
                        w_memrq  = 1'b1;
                        w_rnw    = 1'b0;
                        w_retire = w_ack;
                    end
                    4'd2, 4'd3: begin
                        Asel     = 1'b1;
                        w_memrq  = 1'b1;
                        M        = (F == 4'd2) ? 2'b01 : 2'b11;
                        AccEn    = w_ack;
                        w_retire = w_ack;
                    end
                    4'd4: begin
                        Ysel = 1'b1;
                        PCEn = 1'b1;
                    end
                    4'd5: begin
                        Ysel = 1'b1;
                        PCEn = ~N;
                    end
                    4'd6: begin
                        Ysel = 1'b1;
                        PCEn = ~Z;
                    end
                    default: ;
                endcase
                if (w_retire) begin
                    if (F == 4'd7)
                        w_next = S_HALT;
                    else if (step_en)
                        w_next = S_PAUSE;
                    else
                        w_next = S_FETCH;
                end
            end
            S_PAUSE: begin
                if (step || !step_en)
                    w_next = S_FETCH;
            end
            S_HALT: begin
                Halted = 1'b1;
            end
            default: w_next = S_FETCH;
        endcase
    end

endmodule

// File: tb/tb_mu0_control.sv
// Bench for mu0_control: per-cycle comparison against a behavioural
// model of the sequencer plus directed literal checks.
module tb_mu0_control;

    localparam int CW = 8;

    localparam int PH_FETCH = 0;
    localparam int PH_EXEC  = 1;
    localparam int PH_PAUSE = 2;
    localparam int PH_HALT  = 3;

    typedef struct packed {
        logic       asel;
        logic       xsel;
        logic       ysel;
        logic [1:0] m;
        logic       pcen;
        logic       iren;
        logic       accen;
        logic       memrq;
        logic       rnw;
        logic       halted;
        logic       fetch;
    } outs_t;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [3:0]    F;
    logic          N;
    logic          Z;
    logic          step_en;
    logic          step;
    logic          Asel;
    logic          Xsel;
    logic          Ysel;
    logic [1:0]    M;
    logic          PCEn;
    logic          IREn;
    logic          AccEn;
    logic          Halted;
    logic          fetch;
    logic [CW-1:0] instr_count;

    int total = 0;
    int bad   = 0;

    mu0_mem_if mem ();

    mu0_control #(.CNT_W(CW)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .F           (F),
        .N           (N),
        .Z           (Z),
        .step_en     (step_en),
        .step        (step),
        .mem         (mem.master),
        .Asel        (Asel),
        .Xsel        (Xsel),
        .Ysel        (Ysel),
        .M           (M),
        .PCEn        (PCEn),
        .IREn        (IREn),
        .AccEn       (AccEn),
        .Halted      (Halted),
        .fetch       (fetch),
        .instr_count (instr_count)
    );

    always #5 clk = ~clk;

    // Behavioural model: phase of the instruction cycle and retire count.
    int            m_ph;
    logic [CW-1:0] m_cnt;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_ph  <= PH_FETCH;
            m_cnt <= '0;
        end else begin
            case (m_ph)
                PH_FETCH: if (mem.mem_ack) m_ph <= PH_EXEC;
                PH_EXEC: begin
                    if (F > 4'd3 || mem.mem_ack) begin
                        m_cnt <= m_cnt + 1'b1;
                        if (F == 4'd7)    m_ph <= PH_HALT;
                        else if (step_en) m_ph <= PH_PAUSE;
                        else              m_ph <= PH_FETCH;
                    end
                end
                PH_PAUSE: if (step || !step_en) m_ph <= PH_FETCH;
                default: ;
            endcase
        end
    end

    function automatic outs_t expect_outs(int p, logic [3:0] f,
                                          logic n, logic z,
                                          logic ack);
        outs_t e;
        e     = '0;
        e.rnw = 1'b1;
        if (p == PH_FETCH) begin
            e.fetch = 1'b1;
            e.memrq = 1'b1;
            e.xsel  = 1'b1;
            e.m     = 2'b10;
            e.iren  = ack;
            e.pcen  = ack;
        end else if (p == PH_EXEC) begin
            if (f < 4'd4) begin
                e.asel  = 1'b1;
                e.memrq = 1'b1;
                if (f == 4'd1) begin
                    e.rnw = 1'b0;
                end else begin
                    e.m     = (f == 4'd0) ? 2'b00 :
                              (f == 4'd2) ? 2'b01 : 2'b11;
                    e.accen = ack;
                end
            end else if (f < 4'd7) begin
                e.ysel = 1'b1;
                e.pcen = (f == 4'd4) ? 1'b1 :
                         (f == 4'd5) ? ~n : ~z;
            end
        end else if (p == PH_HALT) begin
            e.halted = 1'b1;
        end
        return e;
    endfunction

    outs_t dut_o;
    assign dut_o = '{Asel, Xsel, Ysel, M, PCEn, IREn, AccEn,
                     mem.MEMrq, mem.RnW, Halted, fetch};

    always @(negedge clk) begin
        outs_t e;
        if (reset_n) begin
            e = expect_outs(m_ph, F, N, Z, mem.mem_ack);
            total++;
            if (dut_o !== e || instr_count !== m_cnt) begin
                bad++;
                $display("FAIL cycle t=%0t outs=%h/cnt=%0d want %h/%0d",
                         $time, dut_o, instr_count, e, m_cnt);
            end
        end
    end

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, want %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_n     = 1'b0;
        F           = 4'd0;
        N           = 1'b0;
        Z           = 1'b0;
        step_en     = 1'b0;
        step        = 1'b0;
        mem.mem_ack = 1'b0;
        #3;
        chk("rst_fetch", 32'(fetch), 1);
        chk("rst_cnt", 32'(instr_count), 0);
        chk("rst_halted", 32'(Halted), 0);
        tick();
        tick();
        reset_n = 1'b1;

        // LDA with memory always ready
        F = 4'd0;
        mem.mem_ack = 1'b1;
        #1;
        chk("lda_f_memrq", 32'(mem.MEMrq), 1);
        chk("lda_f_rnw", 32'(mem.RnW), 1);
        chk("lda_f_iren", 32'(IREn), 1);
        chk("lda_f_pcen", 32'(PCEn), 1);
        chk("lda_f_m", 32'(M), 2);
        tick();
        chk("lda_e_asel", 32'(Asel), 1);
        chk("lda_e_accen", 32'(AccEn), 1);
        chk("lda_e_m", 32'(M), 0);
        tick();
        chk("lda_cnt", 32'(instr_count), 1);

        // STA with three wait cycles
        F = 4'd1;
        tick();
        mem.mem_ack = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("sta_wait_memrq", 32'(mem.MEMrq), 1);
            chk("sta_wait_rnw", 32'(mem.RnW), 0);
            chk("sta_wait_en", 32'({PCEn, IREn, AccEn}), 0);
            tick();
        end
        mem.mem_ack = 1'b1;
        #1;
        chk("sta_ack_rnw", 32'(mem.RnW), 0);
        chk("sta_ack_en", 32'({PCEn, IREn, AccEn}), 0);
        tick();
        chk("sta_back_fetch", 32'(fetch), 1);

        // Jump decode: {F, N, Z, expected PCEn}
        begin
            logic [6:0] jv [4];
            jv[0] = {4'd5, 1'b1, 1'b0, 1'b0};
            jv[1] = {4'd5, 1'b0, 1'b0, 1'b1};
            jv[2] = {4'd6, 1'b0, 1'b1, 1'b0};
            jv[3] = {4'd4, 1'b1, 1'b1, 1'b1};
            for (int i = 0; i < 4; i++) begin
                F = jv[i][6:3];
                tick();
                N = jv[i][2];
                Z = jv[i][1];
                #1;
                chk("jmp_ysel", 32'(Ysel), 1);
                chk("jmp_m", 32'(M), 0);
                chk("jmp_pcen", 32'(PCEn), 32'(jv[i][0]));
                tick();
            end
        end

        // Single-step pause after ADD
        step_en = 1'b1;
        F = 4'd2;
        tick();
        tick();
        for (int i = 0; i < 5; i++) begin
            chk("pause_memrq", 32'(mem.MEMrq), 0);
            chk("pause_fetch", 32'(fetch), 0);
            tick();
        end
        step = 1'b1;
        tick();
        step = 1'b0;
        step_en = 1'b0;
        #1;
        chk("step_fetch", 32'(fetch), 1);

        // STP then halt, immune to ack/step
        F = 4'd7;
        tick();
        tick();
        chk("halt_on", 32'(Halted), 1);
        chk("halt_cnt", 32'(instr_count), 8);
        for (int i = 0; i < 10; i++) begin
            mem.mem_ack = i[0];
            step = i[1];
            tick();
            chk("halt_hold", 32'(Halted), 1);
            chk("halt_cnt_hold", 32'(instr_count), 8);
        end
        step = 1'b0;
        mem.mem_ack = 1'b1;
        #1;
        reset_n = 1'b0;
        #1;
        chk("arst_halted", 32'(Halted), 0);
        chk("arst_cnt", 32'(instr_count), 0);
        chk("arst_fetch", 32'(fetch), 1);
        reset_n = 1'b1;

        // Counter wrap through NOPs
        F = 4'd8;
        for (int i = 0; i < 2 * ((1 << CW) - 1); i++)
            tick();
        chk("wrap_full", 32'(instr_count), (1 << CW) - 1);
        tick();
        tick();
        chk("wrap_zero", 32'(instr_count), 0);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mu0_control.md
Name: mu0_control

Overview:
- Fetch/execute sequencer for the MU0 12-bit-address CPU. It drives the select lines of the datapath multiplexers: address mux, ALU X mux and ALU Y mux.
- It also drives the register enables (PC, IR, ACC), the ALU function and the memory request strobes.
- It consumes the IR opcode and the ACC flags, and adds a memory acknowledge handshake, single-step pause and a retired-instruction counter.

Parameters:
- CNT_W, 16, width of retired-instruction counter.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  reset; asynchronous and active-low. One clock; all state resets immediately on reset_n=0.
- F  in  4  opcode, IR[15:12].
- N  in  1  ACC negative flag.
- Z  in  1  ACC zero flag.
- mem_ack  in  1  memory completes the current request this cycle.
- step_en  in  1  single-step mode enable.
- step  in  1  advance one instruction while paused; level-sampled.
- Asel  out  1  address mux select: 0=PC, 1=IR[11:0].
- Xsel  out  1  ALU X select: 0=ACC, 1=PC.
- Ysel  out  1  ALU Y select: 0=memory data, 1=IR[11:0].
- M  out  2  ALU function: 00=Y, 01=X+Y, 10=X+1, 11=X-Y.
- PCEn  out  1  PC load enable.
- IREn  out  1  IR load enable.
- AccEn  out  1  ACC load enable.
- MEMrq  out  1  memory request.
- RnW  out  1  1=read, 0=write.
- Halted  out  1  processor stopped.
- fetch  out  1  high in FETCH state.
- instr_count  out  CNT_W  instructions retired.

Behaviour:
- Registers are the state (FETCH, EXEC, PAUSE, HALT) and instr_count. All other outputs decode combinationally from the state, F, N, Z and mem_ack.
- Reset: state=FETCH, instr_count=0. Reset asserted mid-request aborts it; the FSM re-enters FETCH.
- Default for every output is 0, except RnW, which defaults to 1.
- FETCH:
  - Asel=0, MEMrq=1, RnW=1, Xsel=1, M=10.
  - IREn=PCEn=mem_ack.
  - On mem_ack go to EXEC; otherwise hold.
- EXEC, decoded on F:
  - 0 LDA: Asel=1, MEMrq=1, RnW=1, Ysel=0, M=00, AccEn=mem_ack.
  - 1 STA: Asel=1, MEMrq=1, RnW=0.
  - 2 ADD: Asel=1, MEMrq=1, RnW=1, Xsel=0, Ysel=0, M=01, AccEn=mem_ack.
  - 3 SUB: as ADD but M=11.
  - 4 JMP: Ysel=1, M=00, PCEn=1.
  - 5 JGE: Ysel=1, M=00, PCEn=~N.
  - 6 JNE: Ysel=1, M=00, PCEn=~Z.
  - 7 STP: all enables 0, next state HALT.
  - 8-15: NOP, all enables 0.
- Completion:
  - Memory ops (F=0..3) complete in the cycle mem_ack=1 and otherwise hold EXEC with enables 0.
  - Non-memory ops complete in one cycle.
- On completion, instr_count increments, wrapping from all-ones to 0. STP counts.
  - Next state is HALT if F=7.
  - Otherwise PAUSE if step_en=1.
  - Otherwise FETCH.
- PAUSE:
  - All enables 0, MEMrq=0.
  - Go to FETCH when step=1 or step_en=0; otherwise hold.
- HALT: Halted=1, all enables 0, MEMrq=0. Exit only via reset.
- mem_ack while MEMrq=0 is ignored.
- No register enable is ever asserted while MEMrq=1 and mem_ack=0.
- Minimum CPI is 2 (FETCH+EXEC) with mem_ack tied high.

Test Plan:
- mem_ack=1, step_en=0, F=0 -> FETCH cycle has MEMrq=1, RnW=1, IREn=1, PCEn=1, M=10. Next cycle (EXEC) has Asel=1, AccEn=1, M=00. instr_count goes 0->1 after 2 clocks.
- F=1 (STA), mem_ack low for 3 EXEC cycles, then high -> MEMrq=1 and RnW=0 held for 4 cycles with all enables 0. Return to FETCH on the 5th edge.
- Jump decode, with Ysel=1 and M=00 in each case:
  - F=5, N=1 -> PCEn=0.
  - F=5, N=0 -> PCEn=1.
  - F=6, Z=1 -> PCEn=0.
  - F=4 -> PCEn=1.
- F=7 -> Halted=1 from the next cycle. It stays high for 10 cycles regardless of mem_ack and step, and instr_count stops. Pulsing reset_n low mid-cycle clears Halted and instr_count asynchronously, and the FSM resumes in FETCH.
- step_en=1, F=2 -> after EXEC the FSM enters PAUSE (MEMrq=0) and holds for 5 cycles. step=1 for one cycle -> FETCH on the next edge.
- Preload instr_count to all-ones by running 65535 NOPs (F=8) -> the next retirement gives instr_count=0.
